// File: rtl/delay_line_vld.sv
// delay_line_vld: multi-lane delay line with per-stage valid tracking and a
// runtime-programmable depth (0..MAX_SHIFT). The depth register only accepts a
// new value while no stage holds a valid item.
// Optional feature macro: DELAY_LINE_STALL_EN adds an 'en' advance strobe; when
// undefined the stages shift every cycle and the 'en' port does not exist.
module delay_line_vld #(
  parameter int MAX_SHIFT = 8,
  parameter int DATA      = 32,
  parameter int LANES     = 1,
  localparam int DW       = $clog2(MAX_SHIFT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [DW-1:0]         cfg_delay,
  output logic                  cfg_err,
  output logic [DW-1:0]         cur_delay,
`ifdef DELAY_LINE_STALL_EN
  input  logic                  en,
`endif
  input  logic                  valid_in,
  input  logic [LANES*DATA-1:0] data_in,
  output logic                  valid_out,
  output logic [LANES*DATA-1:0] data_out,
  output logic                  busy
);

  localparam int W = LANES * DATA;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_SHIFT);

  logic [MAX_SHIFT-1:0] stage_vld;
  logic [W-1:0]         stage_data [MAX_SHIFT];
  logic                 adv;
  logic                 tap_vld;
  logic [W-1:0]         tap_data;

`ifdef DELAY_LINE_STALL_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  // Valid bits shift with the data; reset discards every in-flight item.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld <= '0;
    end else if (adv) begin
      for (int i = MAX_SHIFT - 1; i > 0; i--) begin
        stage_vld[i] <= stage_vld[i-1];
      end
      stage_vld[0] <= valid_in;
    end
  end

  // Data stages carry no reset so they can map onto shift-register primitives;
  // stale contents are hidden by the valid mask at the tap.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = MAX_SHIFT - 1; i > 0; i--) begin
        stage_data[i] <= stage_data[i-1];
      end
      stage_data[0] <= data_in;
    end
  end

  // Depth register: loads (clamped) only while idle, else flags a one-cycle error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_delay <= MAX_D;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we & busy;
      if (cfg_we && !busy) begin
        cur_delay <= (cfg_delay > MAX_D) ? MAX_D : cfg_delay;
      end else begin
        cur_delay <= cur_delay;
      end
    end
  end

  // Output tap: bypass at depth 0, otherwise select stage[cur_delay-1].
  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    if (cur_delay == '0) begin
      tap_vld  = valid_in;
      tap_data = data_in;
    end else begin
      for (int i = 0; i < MAX_SHIFT; i++) begin
        if (cur_delay == DW'(i + 1)) begin
          tap_vld  = stage_vld[i];
          tap_data = stage_data[i];
        end
      end
    end
  end

  assign valid_out = tap_vld;
  assign data_out  = tap_vld ? tap_data : '0;
  assign busy      = |stage_vld;

endmodule

// File: tb/tb_delay_line_vld.sv
// tb_delay_line_vld: randomized bench for delay_line_vld. A history of captured
// inputs indexed by advance count predicts the tap, busy flag, depth register
// and config error each cycle. Build with DELAY_LINE_STALL_EN to exercise 'en'.
module tb_delay_line_vld;

  localparam int MAX_SHIFT = 8;
  localparam int DATA      = 32;
  localparam int LANES     = 4;
  localparam int DW        = $clog2(MAX_SHIFT + 1);
  localparam int W         = LANES * DATA;
  localparam int HN        = 64;
  localparam int NCYC      = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [DW-1:0] cfg_delay;
  logic          cfg_err;
  logic [DW-1:0] cur_delay;
  logic          en;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit           hv [HN];
  logic [W-1:0] hd [HN];
  int           n_adv;
  int           cur_m;
  bit           err_m;
  bit           started;

  delay_line_vld #(.MAX_SHIFT(MAX_SHIFT), .DATA(DATA), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_delay (cfg_delay),
    .cfg_err   (cfg_err),
    .cur_delay (cur_delay),
`ifdef DELAY_LINE_STALL_EN
    .en        (en),
`endif
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Any item captured within the last MAX_SHIFT advances is still inside the line.
  function automatic bit model_busy();
    bit b = 1'b0;
    for (int k = 0; k < MAX_SHIFT; k++) begin
      if (hv[(n_adv - 1 - k) % HN]) b = 1'b1;
    end
    return b;
  endfunction

  function automatic bit tb_adv();
`ifdef DELAY_LINE_STALL_EN
    return en;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    int           mode;
    int           vprob;
    bit           exp_v;
    logic [W-1:0] exp_d;
    bit           b;

    rst = 1'b1; cfg_we = 1'b0; cfg_delay = '0; valid_in = 1'b0; data_in = '0; en = 1'b1;
    n_adv = HN * 4; cur_m = MAX_SHIFT; err_m = 1'b0; started = 1'b0; vprob = 0;
    for (int i = 0; i < HN; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc >= 2) begin
        if (cyc % 32 == 0) begin
          mode  = $urandom_range(0, 2);
          vprob = (mode == 0) ? 90 : (mode == 1) ? 30 : 0;
        end
        rst       = ($urandom_range(0, 249) == 0);
        cfg_we    = ($urandom_range(0, 9) == 0);
        cfg_delay = DW'($urandom_range(0, 15));
        valid_in  = ($urandom_range(0, 99) < vprob);
        en        = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < LANES; k++) data_in[k*DATA +: DATA] = $urandom;
      end

      @(negedge clk);
      if (started) begin
        if (cur_m == 0) begin
          exp_v = valid_in;
          exp_d = valid_in ? data_in : '0;
        end else begin
          exp_v = hv[(n_adv - cur_m) % HN];
          exp_d = exp_v ? hd[(n_adv - cur_m) % HN] : '0;
        end
        check_eq("valid_out", W'(valid_out), W'(exp_v));
        check_eq("data_out",  data_out, exp_d);
        check_eq("busy",      W'(busy), W'(model_busy()));
        check_eq("cur_delay", W'(cur_delay), W'(cur_m));
        check_eq("cfg_err",   W'(cfg_err), W'(err_m));
      end

      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < HN; i++) hv[i] = 1'b0;
        cur_m   = MAX_SHIFT;
        err_m   = 1'b0;
        started = 1'b1;
      end else if (started) begin
        b     = model_busy();
        err_m = cfg_we && b;
        if (cfg_we && !b) cur_m = (int'(cfg_delay) > MAX_SHIFT) ? MAX_SHIFT : int'(cfg_delay);
        if (tb_adv()) begin
          hv[n_adv % HN] = valid_in;
          hd[n_adv % HN] = data_in;
          n_adv++;
        end
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
